iter_shifter: RTL and testbench



---
 rtl/iter_shifter.sv | 86 ++++++++
 tb/tb_iter_shifter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves the working register one bit per clock
// under a start/busy/done handshake, so each bit needs only one 2:1 mux.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// SHIFT | one-bit step per clock while the counter runs down to zero
// DONE  | one-cycle done pulse; shift_out holds the final result
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, step;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic             accept, last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == AMT_W'(1));

  always_comb begin
    case (mode_q)
      2'b00:   step = {work[WIDTH-2:0], 1'b0};
      2'b01:   step = {1'b0, work[WIDTH-1:1]};
      2'b10:   step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: step = {work[0], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == AMT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // shift_out is only written on entry to DONE, so partial results never show
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      cnt       <= '0;
      mode_q    <= 2'b00;
      shift_out <= '0;
    end else if (accept) begin
      work   <= A;
      cnt    <= shamt;
      mode_q <= mode;
      if (shamt == '0) shift_out <= A;
    end else if (state == SHIFT) begin
      work <= step;
      cnt  <= cnt - AMT_W'(1);
      if (last_step) shift_out <= step;
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: cycle-accurate handshake and result checks.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] shift_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_out;

  iter_shifter #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .shamt(shamt), .mode(mode),
    .busy(busy), .done(done), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  // advance into the next cycle; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // start in the current cycle, then walk every cycle through done and back to idle
  task automatic run_op(input string tag, input logic [31:0] a_in, input logic [4:0] amt,
                        input logic [1:0] md, input logic [31:0] exp);
    A = a_in; shamt = amt; mode = md; start = 1'b1;
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_done"}, done, 1'b0);
    tick();
    start = 1'b0; A = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    for (int i = 0; i < int'(amt); i++) begin
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_nodone"}, done, 1'b0);
      chk({tag, "_hold"}, shift_out, last_out);
      tick();
    end
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_done_busy"}, busy, 1'b0);
    chk({tag, "_out"}, shift_out, exp);
    last_out = exp;
    tick();
    chk1({tag, "_post_done"}, done, 1'b0);
    chk1({tag, "_post_busy"}, busy, 1'b0);
    chk({tag, "_post_out"}, shift_out, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; shamt = '0; mode = '0;
    last_out = 32'h0;
    tick(); tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_out", shift_out, 32'h0);
    rst = 1'b0;
    tick();

    run_op("ror1",    32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000);
    run_op("sra4",    32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
    run_op("srl4",    32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
    run_op("sll31",   32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000);
    run_op("ror0",    32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678);
    run_op("ror8",    32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456);
    run_op("sra31",   32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    run_op("srl31",   32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);

    // start held high through the operation; new operands must not leak in
    A = 32'h0000_000F; shamt = 5'd8; mode = 2'b00; start = 1'b1;
    chk1("hold_idle_busy", busy, 1'b0);
    tick();
    A = 32'hFFFF_FFFF; shamt = 5'd2;
    for (int i = 0; i < 8; i++) begin
      chk1("hold_busy", busy, 1'b1);
      chk1("hold_nodone", done, 1'b0);
      chk("hold_partial", shift_out, last_out);
      tick();
    end
    chk1("hold_done", done, 1'b1);
    chk("hold_out", shift_out, 32'h0000_0F00);
    tick();
    chk1("hold_single_done", done, 1'b0);
    chk1("hold_idle_again", busy, 1'b0);
    tick();
    chk1("hold_reaccept_busy", busy, 1'b1);
    start = 1'b0;
    tick();
    chk1("hold_reaccept_busy2", busy, 1'b1);
    tick();
    chk1("hold_reaccept_done", done, 1'b1);
    chk("hold_reaccept_out", shift_out, 32'hFFFF_FFFC);
    last_out = 32'hFFFF_FFFC;
    tick();

    // reset mid-operation discards it
    A = 32'hA5A5_A5A5; shamt = 5'd10; mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk1("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk("abort_out", shift_out, 32'h0);
    last_out = 32'h0;
    for (int i = 0; i < 12; i++) begin
      chk1("abort_no_done", done, 1'b0);
      tick();
    end
    run_op("after_abort", 32'hA5A5_A5A5, 5'd10, 2'b01, 32'h0029_6969);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
